// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end feeding the IF/ID register.
// Owns the fetch PC and issues one request at a time over a req/gnt + rvalid
// instruction-memory interface. Returned words are held in a 2-entry FIFO so
// decode stalls never lose a response. An EX redirect flushes the FIFO and
// squashes any in-flight fetch.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   imem_req/addr     fetch request and word-aligned address (combinational)
//   imem_gnt          memory accepts the request this cycle
//   imem_rvalid/rdata response word
//   redirect_valid/pc EX redirect (taken branch / jal / jalr) and its target
//   stall_IF          hazard unit: hold the head entry
//   INST_IF, PC_IF, PC_plus_4_IF, inst_valid_IF
//                     head of the FIFO, combinational; NOP/0/0/0 when empty
module if_fetch_unit #(
  parameter int unsigned                INST_WIDTH      = 32,
  parameter int unsigned                INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [INST_WIDTH-1:0]      NOP_INST        = INST_WIDTH'(32'h0000_0013)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_req,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [INST_WIDTH-1:0]      imem_rdata,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  input  logic                       stall_IF,
  output logic [INST_WIDTH-1:0]      INST_IF,
  output logic [INST_ADDR_WIDTH-1:0] PC_IF,
  output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF,
  output logic                       inst_valid_IF
);

  localparam int unsigned AW = INST_ADDR_WIDTH;
  localparam int unsigned IW = INST_WIDTH;

  localparam logic [AW-1:0] PC_STEP    = AW'(4);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // no request outstanding
    S_WAIT = 2'd1,  // request granted, response will be kept
    S_DROP = 2'd2   // request granted, response will be discarded
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [AW-1:0]    r_fetch_pc;
  logic [AW-1:0]    r_pend_pc;

  logic [IW-1:0]    r_fifo_inst [2];
  logic [AW-1:0]    r_fifo_pc   [2];
  logic [1:0]       r_count;
  logic             r_rd_ptr;
  logic             r_wr_ptr;

  logic             w_req;
  logic             w_grant;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;

  // Request only with room for the response, so the FIFO can never overflow.
  assign w_req   = rst_n & (r_state == S_REQ) & (r_count <= 2'd1) & ~redirect_valid;
  assign w_grant = w_req & imem_gnt;

  // A redirect squashes the response arriving in the same cycle.
  assign w_push  = (r_state == S_WAIT) & imem_rvalid & ~redirect_valid;
  assign w_valid = rst_n & (r_count != 2'd0);
  assign w_pop   = w_valid & ~stall_IF & ~redirect_valid;

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc & ALIGN_MASK;

  // Head of FIFO presented combinationally to decode.
  assign inst_valid_IF = w_valid;
  assign INST_IF       = w_valid ? r_fifo_inst[r_rd_ptr] : NOP_INST;
  assign PC_IF         = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign PC_plus_4_IF  = w_valid ? (r_fifo_pc[r_rd_ptr] + PC_STEP) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_grant) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect with no response yet leaves a stale word to swallow.
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end else if (redirect_valid) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Fetch PC, pending PC and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= '0;
      r_count    <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_pend_pc <= r_fetch_pc;
      end
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ALIGN_MASK;
        r_count    <= 2'd0;
        r_rd_ptr   <= 1'b0;
        r_wr_ptr   <= 1'b0;
      end else begin
        if (w_push) begin
          a_no_overflow: assert (r_count != 2'd2);
          r_fetch_pc <= r_pend_pc + PC_STEP;
          r_wr_ptr   <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage; contents are only observed while the entry is counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_pend_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with a small memory
// responder (grant controlled by the bench, response mem_lat cycles after grant).
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_IF;
  logic [31:0] INST_IF;
  logic [31:0] PC_IF;
  logic [31:0] PC_plus_4_IF;
  logic        inst_valid_IF;

  int n_vec = 0;
  int n_bad = 0;

  // Memory responder state.
  logic        mem_flush;
  int          mem_lat;
  logic        granted_q;
  logic [31:0] gaddr_q;
  int          grant_cnt;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr_q;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_IF       (stall_IF),
    .INST_IF        (INST_IF),
    .PC_IF          (PC_IF),
    .PC_plus_4_IF   (PC_plus_4_IF),
    .inst_valid_IF  (inst_valid_IF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // Record handshakes at the active edge.
  always @(posedge clk) begin
    granted_q <= imem_req & imem_gnt;
    gaddr_q   <= imem_addr;
    if (mem_flush) grant_cnt <= 0;
    else if (imem_req && imem_gnt) grant_cnt <= grant_cnt + 1;
  end

  // Response driven mid-cycle so the DUT sees it at the following edge(s).
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (mem_flush) begin
      mem_pend = 1'b0;
    end else begin
      if (granted_q) begin
        mem_pend   = 1'b1;
        mem_cnt    = mem_lat;
        mem_addr_q = gaddr_q;
      end
      if (mem_pend) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(mem_addr_q);
          mem_pend    = 1'b0;
        end
      end
    end
  end

  // Two-cycle reset; returns at the negedge where rst_n is released (cycle k=0).
  task automatic do_reset(input logic gnt_v);
    @(negedge clk);
    rst_n = 1'b0; mem_flush = 1'b1; stall_IF = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'd0; imem_gnt = gnt_v; mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_flush = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_bad++; $display("FAIL reset.req: got %b want 0", imem_req);
    end
    n_vec++;
    if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== {1'b0, NOP, 32'd0, 32'd0}) begin
      n_bad++; $display("FAIL reset.head: got %b %h %h %h want 0 %h 0 0",
                        inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF, NOP);
    end
  endtask

  task automatic test_stream();
    logic er, ev; logic [31:0] ea, epc; logic [96:0] eh;
    do_reset(1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      er  = (k % 2 == 0);
      ea  = 32'(2 * k);
      ev  = er && (k >= 2);
      epc = 32'(2 * k - 4);
      eh  = ev ? {1'b1, word_of(epc), epc, epc + 32'd4} : {1'b0, NOP, 32'd0, 32'd0};
      n_vec++;
      if (imem_req !== er) begin n_bad++; $display("FAIL stream.req k=%0d: got %b want %b", k, imem_req, er); end
      if (er) begin
        n_vec++;
        if (imem_addr !== ea) begin n_bad++; $display("FAIL stream.addr k=%0d: got %h want %h", k, imem_addr, ea); end
      end
      n_vec++;
      if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== eh) begin
        n_bad++; $display("FAIL stream.head k=%0d: got %h want %h", k, {inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF}, eh);
      end
    end
  endtask

  task automatic test_stall();
    logic er, ev; logic [31:0] ea, epc; logic [96:0] eh;
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      stall_IF = (k >= 2 && k <= 7);
      #1;
      er = 1'b0; ev = 1'b0; ea = 32'd0; epc = 32'd0;
      case (k)
        0:                  begin er = 1'b1; ea = 32'h0; end
        2:                  begin er = 1'b1; ea = 32'h4; ev = 1'b1; epc = 32'h0; end
        3, 4, 5, 6, 7, 8:   begin ev = 1'b1; epc = 32'h0; end
        9:                  begin er = 1'b1; ea = 32'h8; ev = 1'b1; epc = 32'h4; end
        11:                 begin er = 1'b1; ea = 32'hC; ev = 1'b1; epc = 32'h8; end
        default: ;
      endcase
      eh = ev ? {1'b1, word_of(epc), epc, epc + 32'd4} : {1'b0, NOP, 32'd0, 32'd0};
      n_vec++;
      if (imem_req !== er) begin n_bad++; $display("FAIL stall.req k=%0d: got %b want %b", k, imem_req, er); end
      if (er) begin
        n_vec++;
        if (imem_addr !== ea) begin n_bad++; $display("FAIL stall.addr k=%0d: got %h want %h", k, imem_addr, ea); end
      end
      n_vec++;
      if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== eh) begin
        n_bad++; $display("FAIL stall.head k=%0d: got %h want %h", k, {inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF}, eh);
      end
    end
    stall_IF = 1'b0;
  endtask

  task automatic test_gnt_hold();
    logic er, ev; logic [31:0] ea, epc; logic [96:0] eh;
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) imem_gnt = 1'b1;
      #1;
      er = 1'b0; ev = 1'b0; ea = 32'd0; epc = 32'd0;
      case (k)
        0, 1, 2, 3: begin er = 1'b1; ea = 32'h0; end
        5:          begin er = 1'b1; ea = 32'h4; ev = 1'b1; epc = 32'h0; end
        default: ;
      endcase
      eh = ev ? {1'b1, word_of(epc), epc, epc + 32'd4} : {1'b0, NOP, 32'd0, 32'd0};
      n_vec++;
      if (imem_req !== er) begin n_bad++; $display("FAIL gnt.req k=%0d: got %b want %b", k, imem_req, er); end
      if (er) begin
        n_vec++;
        if (imem_addr !== ea) begin n_bad++; $display("FAIL gnt.addr k=%0d: got %h want %h", k, imem_addr, ea); end
      end
      n_vec++;
      if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== eh) begin
        n_bad++; $display("FAIL gnt.head k=%0d: got %h want %h", k, {inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF}, eh);
      end
      if (k == 3 || k == 4) begin
        n_vec++;
        if (grant_cnt !== k - 3) begin n_bad++; $display("FAIL gnt.count k=%0d: got %0d want %0d", k, grant_cnt, k - 3); end
      end
    end
  endtask

  task automatic test_redirect_wait();
    logic er, ev; logic [31:0] ea, epc; logic [96:0] eh;
    do_reset(1'b1);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 4) mem_lat = 3;
      if (k == 5) begin redirect_valid = 1'b1; redirect_pc = 32'h100; end
      if (k == 6) redirect_valid = 1'b0;
      if (k == 8) mem_lat = 1;
      #1;
      er = 1'b0; ev = 1'b0; ea = 32'd0; epc = 32'd0;
      case (k)
        0:  begin er = 1'b1; ea = 32'h0; end
        2:  begin er = 1'b1; ea = 32'h4; ev = 1'b1; epc = 32'h0; end
        4:  begin er = 1'b1; ea = 32'h8; ev = 1'b1; epc = 32'h4; end
        8:  begin er = 1'b1; ea = 32'h100; end
        10: begin er = 1'b1; ea = 32'h104; ev = 1'b1; epc = 32'h100; end
        default: ;
      endcase
      eh = ev ? {1'b1, word_of(epc), epc, epc + 32'd4} : {1'b0, NOP, 32'd0, 32'd0};
      n_vec++;
      if (imem_req !== er) begin n_bad++; $display("FAIL redir_wait.req k=%0d: got %b want %b", k, imem_req, er); end
      if (er) begin
        n_vec++;
        if (imem_addr !== ea) begin n_bad++; $display("FAIL redir_wait.addr k=%0d: got %h want %h", k, imem_addr, ea); end
      end
      n_vec++;
      if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== eh) begin
        n_bad++; $display("FAIL redir_wait.head k=%0d: got %h want %h", k, {inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF}, eh);
      end
    end
  endtask

  task automatic test_redirect_full();
    logic er, ev; logic [31:0] ea, epc; logic [96:0] eh;
    do_reset(1'b1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) stall_IF = 1'b1;
      if (k == 3) begin redirect_valid = 1'b1; redirect_pc = 32'h203; end
      if (k == 4) begin redirect_valid = 1'b0; stall_IF = 1'b0; imem_gnt = 1'b0; end
      if (k == 5) begin redirect_valid = 1'b1; redirect_pc = 32'h300; end
      if (k == 6) begin redirect_valid = 1'b0; imem_gnt = 1'b1; end
      #1;
      er = 1'b0; ev = 1'b0; ea = 32'd0; epc = 32'd0;
      case (k)
        0: begin er = 1'b1; ea = 32'h0; end
        2: begin er = 1'b1; ea = 32'h4; ev = 1'b1; epc = 32'h0; end
        3: begin ev = 1'b1; epc = 32'h0; end
        4: begin er = 1'b1; ea = 32'h200; end
        6: begin er = 1'b1; ea = 32'h300; end
        8: begin er = 1'b1; ea = 32'h304; ev = 1'b1; epc = 32'h300; end
        default: ;
      endcase
      eh = ev ? {1'b1, word_of(epc), epc, epc + 32'd4} : {1'b0, NOP, 32'd0, 32'd0};
      n_vec++;
      if (imem_req !== er) begin n_bad++; $display("FAIL redir_full.req k=%0d: got %b want %b", k, imem_req, er); end
      if (er) begin
        n_vec++;
        if (imem_addr !== ea) begin n_bad++; $display("FAIL redir_full.addr k=%0d: got %h want %h", k, imem_addr, ea); end
      end
      n_vec++;
      if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== eh) begin
        n_bad++; $display("FAIL redir_full.head k=%0d: got %h want %h", k, {inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF}, eh);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic er, ev; logic [31:0] ea, epc; logic [96:0] eh;
    do_reset(1'b1);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) mem_lat = 2;
      if (k == 3) rst_n = 1'b0;
      if (k == 4) begin rst_n = 1'b1; mem_lat = 1; end
      #1;
      er = 1'b0; ev = 1'b0; ea = 32'd0; epc = 32'd0;
      case (k)
        0: begin er = 1'b1; ea = 32'h0; end
        2: begin er = 1'b1; ea = 32'h4; ev = 1'b1; epc = 32'h0; end
        4: begin er = 1'b1; ea = 32'h0; end
        6: begin er = 1'b1; ea = 32'h4; ev = 1'b1; epc = 32'h0; end
        default: ;
      endcase
      eh = ev ? {1'b1, word_of(epc), epc, epc + 32'd4} : {1'b0, NOP, 32'd0, 32'd0};
      n_vec++;
      if (imem_req !== er) begin n_bad++; $display("FAIL rst_mid.req k=%0d: got %b want %b", k, imem_req, er); end
      if (er) begin
        n_vec++;
        if (imem_addr !== ea) begin n_bad++; $display("FAIL rst_mid.addr k=%0d: got %h want %h", k, imem_addr, ea); end
      end
      n_vec++;
      if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== eh) begin
        n_bad++; $display("FAIL rst_mid.head k=%0d: got %h want %h", k, {inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF}, eh);
      end
    end
  endtask

  task automatic test_wrap();
    logic er, ev; logic [31:0] ea, epc; logic [96:0] eh;
    do_reset(1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; end
      if (k == 1) redirect_valid = 1'b0;
      #1;
      er = 1'b0; ev = 1'b0; ea = 32'd0; epc = 32'd0;
      case (k)
        1: begin er = 1'b1; ea = 32'hFFFF_FFFC; end
        3: begin er = 1'b1; ea = 32'h0; ev = 1'b1; epc = 32'hFFFF_FFFC; end
        5: begin er = 1'b1; ea = 32'h4; ev = 1'b1; epc = 32'h0; end
        default: ;
      endcase
      eh = ev ? {1'b1, word_of(epc), epc, epc + 32'd4} : {1'b0, NOP, 32'd0, 32'd0};
      n_vec++;
      if (imem_req !== er) begin n_bad++; $display("FAIL wrap.req k=%0d: got %b want %b", k, imem_req, er); end
      if (er) begin
        n_vec++;
        if (imem_addr !== ea) begin n_bad++; $display("FAIL wrap.addr k=%0d: got %h want %h", k, imem_addr, ea); end
      end
      n_vec++;
      if ({inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF} !== eh) begin
        n_bad++; $display("FAIL wrap.head k=%0d: got %h want %h", k, {inst_valid_IF, INST_IF, PC_IF, PC_plus_4_IF}, eh);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_gnt       = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    stall_IF       = 1'b0;
    mem_flush      = 1'b1;
    mem_lat        = 1;
    mem_pend       = 1'b0;
    mem_cnt        = 0;
    mem_addr_q     = 32'd0;

    test_reset();
    test_stream();
    test_stall();
    test_gnt_hold();
    test_redirect_wait();
    test_redirect_full();
    test_reset_mid();
    test_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
